// File: rtl/q3_pkg.sv
// q3_pkg: shared definitions for the q3 serializer slice.
//   - 3-bit FSM state encodings and the matching state enum
//   - idle (mark) level of the serial line
package q3_pkg;

    localparam logic [2:0] st_idle_enc   = 3'd0;
    localparam logic [2:0] st_start_enc  = 3'd1;
    localparam logic [2:0] st_data_enc   = 3'd2;
    localparam logic [2:0] st_parity_enc = 3'd3;
    localparam logic [2:0] st_stop_enc   = 3'd4;

    localparam logic line_idle = 1'b1;

    typedef enum logic [2:0] {
        StIdle   = st_idle_enc,
        StStart  = st_start_enc,
        StData   = st_data_enc,
        StParity = st_parity_enc,
        StStop   = st_stop_enc
    } ser_state_e;

endpackage

// File: rtl/q3_shift_reg.sv
// q3_shift_reg: WIDTH-bit parallel-load, shift-right register.
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous active-high reset (clears the register)
//   load      - load load_data (takes priority over shift)
//   shift     - shift right by one, zero fill at the MSB
//   load_data - parallel word to load
//   bit0      - current bit 0 of the register
module q3_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             bit0
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = load_data;
        end else if (shift) begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bit0 = sr_q[0];

endmodule

// File: rtl/q3_serializer.sv
// q3_serializer: parallel-to-serial framer feeding the q3_dff register stage.
// Frame: start bit (0), WIDTH data bits LSB-first, optional parity bit, stop bit (1).
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-high reset; drops any frame in flight
//   in_data  - word to transmit, sampled on an accepted handshake
//   in_valid - producer has a word on in_data
//   in_ready - high only in IDLE
//   ser_out  - registered serial line, idles high
//   busy     - high in every non-IDLE state
//   done     - one-cycle pulse aligned with the stop bit
module q3_serializer
    import q3_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    ser_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic par_q, par_d;
    logic ser_out_q, ser_out_d;
    logic done_q, done_d;
    logic sr_load, sr_shift, sr_bit0;

    q3_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (sr_load),
        .shift     (sr_shift),
        .load_data (in_data),
        .bit0      (sr_bit0)
    );

    // Next state, counter, parity and shift-register control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StStart;
                    sr_load = 1'b1;
                    cnt_d   = '0;
                    par_d   = (^in_data) ^ ODD_PARITY;
                end
            end
            StStart: begin
                // The output register takes bit 0 on this edge, so advance now and
                // bit 0 of the register always holds the next bit to put on the line.
                sr_shift = 1'b1;
                state_d  = StData;
            end
            StData: begin
                sr_shift = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = PARITY_EN ? StParity : StStop;
                end
            end
            StParity: state_d = StStop;
            StStop:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Line level and done are registered from the state being entered.
    always_comb begin
        ser_out_d = line_idle;
        unique case (state_d)
            StStart:  ser_out_d = 1'b0;
            StData:   ser_out_d = sr_bit0;
            StParity: ser_out_d = par_q;
            default:  ser_out_d = line_idle;
        endcase
        done_d = (state_d == StStop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            par_q     <= 1'b0;
            ser_out_q <= line_idle;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            par_q     <= par_d;
            ser_out_q <= ser_out_d;
            done_q    <= done_d;
        end
    end

    assign ser_out  = ser_out_q;
    assign done     = done_q;
    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);

endmodule

// File: doc/q3_serializer.md
# q3_serializer

Parallel-to-serial framer that turns parallel words into the bit stream driven into the `d` input of the downstream `q3_dff` register stage. It accepts a word through a valid/ready handshake and shifts out one frame: start bit, data bits LSB-first, an optional parity bit, and a stop bit. It runs in the same single clock domain as `q3_dff`; the `ser_out` → `q3_dff` path adds exactly one cycle.

## Interface
- `WIDTH`, 8: data word width. Legal range is WIDTH ≥ 2.
- `PARITY_EN`, 1: 1 inserts a parity bit after the data bits; 0 omits it.
- `ODD_PARITY`, 0: 0 selects even parity; 1 selects odd parity. Ignored when `PARITY_EN` = 0.
- `clk` input 1: single clock. All state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_data` input WIDTH: word to transmit. Sampled only on an accepted handshake.
- `in_valid` input 1: producer has a word on `in_data`.
- `in_ready` output 1: serializer can accept a word. High only in IDLE.
- `ser_out` output 1: registered serial line that feeds `q3_dff` `d`. Idle level is 1.
- `busy` output 1: high in every non-IDLE state.
- `done` output 1: one-cycle pulse, high during the STOP cycle.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Encodings are localparams in the shared package.
- IDLE:
  - `ser_out`=1, `in_ready`=1, `busy`=0.
  - If `in_valid`=1 at a rising edge, a handshake occurs: capture `in_data` into the shift register, compute the parity bit, clear the bit counter, and go to START.
- START: `ser_out`=0 for one cycle, then go to DATA.
- DATA:
  - `ser_out` = shift-register bit 0; the register shifts right each cycle.
  - The bit counter (width $clog2(WIDTH)) increments each cycle.
  - After WIDTH cycles, go to PARITY if `PARITY_EN`=1, else to STOP.
- PARITY:
  - `ser_out` = ^word when even parity is selected, ~^word when odd. The word is the captured one, never live `in_data`.
  - Lasts one cycle, then go to STOP.
- STOP: `ser_out`=1 and `done`=1 for one cycle, then go to IDLE.
- `in_valid` outside IDLE is ignored. `in_data` may change freely after the handshake.
- The producer must hold `in_valid` and `in_data` until `in_ready` is seen. `in_valid` may rise in any state.
- Reset, including mid-frame:
  - On the next edge: state=IDLE, `ser_out`=1, `busy`=0, `done`=0, `in_ready`=1, counter=0.
  - The frame in flight is dropped with no partial parity or stop bit.
  - If reset and a handshake fall on the same edge, reset wins and the word is not accepted.

## Timing
- Handshake at edge N → START bit on `ser_out` in cycle N+1. Data bit k appears in cycle N+2+k.
- PARITY bit in cycle N+2+WIDTH (when enabled). STOP bit in cycle N+2+WIDTH+P, where P = `PARITY_EN`.
- `in_ready` returns high in cycle N+3+WIDTH+P, so back-to-back words are spaced WIDTH+P+3 cycles apart. There is always at least one idle-high cycle between frames.
- `done` is high for exactly one cycle per completed frame, aligned with the stop bit.
- All outputs are registered or decoded from the state register only; there is no combinational path from any input to any output.
- Downstream `q3_dff` `q` equals `ser_out` delayed by one cycle.

## Structure
- Shared package/include `q3_pkg`: state encodings (3-bit localparams) and the idle line level.
- One sub-module, `q3_shift_reg`: WIDTH-bit parallel-load, shift-right register with `load`/`shift` enables and a bit-0 output.
- The top level holds the FSM, bit counter, parity register and output registers.

## Test plan
- After reset with `in_valid`=0: `ser_out`=1, `in_ready`=1, `busy`=0, `done`=0 for 10 cycles.
- WIDTH=8, even parity, send 8'hA5 → `ser_out` = 0, 1,0,1,0,0,1,0,1, 0, 1. `done` pulses on the final 1. The next handshake is 12 cycles after the first.
- Odd parity, send 8'h07 → parity bit = 0. With `PARITY_EN`=0, send 8'h07 → frame is 10 bits with no parity bit.
- Hold `in_valid`=1 continuously with changing `in_data` → only words presented while `in_ready`=1 are sent, each intact. Words 8'h00 and 8'hFF are included.
- Assert `reset` during data bit 3 of 8'h3C → next cycle `ser_out`=1 and IDLE. A following 8'h81 frame is transmitted correctly.
- With `q3_dff` attached → `q` matches `ser_out` delayed by one cycle over a full 8'hA5 frame.
